mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetches and load/stores
// onto an 8-bit RAM bus with one-cycle read latency.
module mem_ctrl #(
  parameter int unsigned RAM_ADDR_WIDTH = 17
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic        clear_in
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, DONE} state_t;

  state_t      state;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic [2:0]  nbytes;
  logic [2:0]  iss_cnt;
  logic [2:0]  cap_cnt;
  logic        is_fetch;
  logic        p1, p2;
  logic [1:0]  idx1, idx2;
  logic [31:0] iss_addr;
  logic [31:0] merged;

  function automatic logic is_io(input logic [31:0] a);
    return a[RAM_ADDR_WIDTH -: 2] == 2'b11;
  endfunction

  function automatic logic [2:0] size_n(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Address of the next unissued byte and the read word with the arriving byte merged in
  always_comb begin
    iss_addr = base + 32'(iss_cnt);
    merged = rbuf;
    merged[{idx2, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      base     <= '0;
      wdata    <= '0;
      rbuf     <= '0;
      nbytes   <= '0;
      iss_cnt  <= '0;
      cap_cnt  <= '0;
      is_fetch <= 1'b0;
      p1       <= 1'b0;
      p2       <= 1'b0;
      idx1     <= '0;
      idx2     <= '0;
      mem_a    <= '0;
      mem_wr   <= 1'b0;
      mem_dout <= '0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
    end else begin
      mem_a    <= '0;
      mem_wr   <= 1'b0;
      mem_dout <= '0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (rdy_in && ls_req) begin
            base     <= ls_addr;
            wdata    <= ls_wdata;
            nbytes   <= size_n(ls_size);
            is_fetch <= 1'b0;
            cap_cnt  <= '0;
            rbuf     <= '0;
            p2       <= 1'b0;
            if (ls_wr) begin
              state <= STORE;
              if (is_io(ls_addr) && io_buffer_full) begin
                iss_cnt <= '0;
              end else begin
                mem_a    <= ls_addr;
                mem_wr   <= 1'b1;
                mem_dout <= ls_wdata[7:0];
                iss_cnt  <= 3'd1;
              end
            end else begin
              state   <= LOAD;
              mem_a   <= ls_addr;
              p1      <= 1'b1;
              idx1    <= '0;
              iss_cnt <= 3'd1;
            end
          end else if (rdy_in && if_req && !clear_in) begin
            state    <= FETCH;
            base     <= if_addr;
            nbytes   <= 3'd4;
            is_fetch <= 1'b1;
            cap_cnt  <= '0;
            rbuf     <= '0;
            p2       <= 1'b0;
            mem_a    <= if_addr;
            p1       <= 1'b1;
            idx1     <= '0;
            iss_cnt  <= 3'd1;
          end
        end
        FETCH, LOAD: begin
          if (is_fetch && clear_in) begin
            state <= IDLE;
            p1    <= 1'b0;
            p2    <= 1'b0;
          end else if (!rdy_in) begin
            // Bytes in flight are lost to the debug host; rewind to reissue them
            p1      <= 1'b0;
            p2      <= 1'b0;
            iss_cnt <= cap_cnt;
          end else begin
            p2   <= p1;
            idx2 <= idx1;
            p1   <= 1'b0;
            if (iss_cnt != nbytes) begin
              mem_a   <= iss_addr;
              p1      <= 1'b1;
              idx1    <= iss_cnt[1:0];
              iss_cnt <= iss_cnt + 3'd1;
            end
            if (p2) begin
              rbuf    <= merged;
              cap_cnt <= cap_cnt + 3'd1;
              if (cap_cnt + 3'd1 == nbytes) begin
                state <= DONE;
                if (is_fetch) begin
                  if_data <= merged;
                  if_done <= 1'b1;
                end else begin
                  ls_rdata <= merged;
                  ls_done  <= 1'b1;
                end
              end
            end
          end
        end
        STORE: begin
          if (!rdy_in) begin
            state <= STORE;
          end else if (iss_cnt == nbytes) begin
            state   <= DONE;
            ls_done <= 1'b1;
          end else if (!(is_io(iss_addr) && io_buffer_full)) begin
            mem_a    <= iss_addr;
            mem_wr   <= 1'b1;
            mem_dout <= wdata[{iss_cnt[1:0], 3'b000} +: 8];
            iss_cnt  <= iss_cnt + 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: transaction table plus hand-written stall, arbitration,
// flush and reset sequences against a behavioural byte RAM.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req = 1'b0;
  logic        ls_wr = 1'b0;
  logic [1:0]  ls_size = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        clear_in = 1'b0;

  int total = 0;
  int bad = 0;

  logic [7:0] ram [0:262143];

  mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata), .clear_in(clear_in)
  );

  always #5 clk_in = ~clk_in;

  // RAM: data for the address seen this cycle appears on mem_din next cycle
  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  typedef struct {
    logic        fetch;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Runs one request starting at a negedge with the controller idle
  task automatic run_vec(input int id, input vec_t v);
    int n, lat, seq_err, other;
    logic [31:0] sh, data;
    n = v.fetch ? 4 : (v.size == 2'b00 ? 1 : (v.size == 2'b01 ? 2 : 4));
    lat = -1; seq_err = 0; other = 0; data = '0;
    if (v.fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      ls_req = 1'b1; ls_wr = v.wr; ls_size = v.size; ls_addr = v.addr; ls_wdata = v.wdata;
    end
    @(posedge clk_in);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      sh = v.wdata >> (8 * k);
      if (k < n) begin
        if (mem_a !== v.addr + 32'(k) || mem_wr !== v.wr || (v.wr && mem_dout !== sh[7:0]))
          seq_err++;
      end else if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0) begin
        seq_err++;
      end
      if ((v.fetch && ls_done) || (!v.fetch && if_done)) other++;
      if (v.fetch ? if_done : ls_done) begin
        lat = k;
        data = v.fetch ? if_data : ls_rdata;
        break;
      end
    end
    if_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
    @(negedge clk_in);
    check($sformatf("v%0d bus_seq_errors", id), 32'(seq_err), 32'd0);
    check($sformatf("v%0d latency", id), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d wrong_port_done", id), 32'(other), 32'd0);
    if (!v.wr) check($sformatf("v%0d rdata", id), data, v.exp_data);
  endtask

  initial begin
    int ls_k, if_k, both, writes, dones, issues, cnt;
    logic [31:0] ls_d, if_d, w_a;
    logic [7:0]  w_d;

    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h2000] = 8'h78; ram[32'h2001] = 8'h56; ram[32'h2002] = 8'h34; ram[32'h2003] = 8'h12;
    ram[32'h0104] = 8'hCD; ram[32'h0105] = 8'hAB;

    //          fetch wr    size   addr          wdata         exp_data      lat
    vecs[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'h0,        32'h0000_0513, 5};
    vecs[1]  = '{1'b0, 1'b0, 2'b10, 32'h0000_2000, 32'h0,        32'h1234_5678, 5};
    vecs[2]  = '{1'b0, 1'b0, 2'b01, 32'h0000_2002, 32'h0,        32'h0000_1234, 3};
    vecs[3]  = '{1'b0, 1'b0, 2'b00, 32'h0000_2003, 32'h0,        32'h0000_0012, 2};
    vecs[4]  = '{1'b1, 1'b0, 2'b10, 32'h0000_2000, 32'h0,        32'h1234_5678, 5};
    vecs[5]  = '{1'b0, 1'b1, 2'b10, 32'h0000_3000, 32'hCAFE_F00D, 32'h0,        4};
    vecs[6]  = '{1'b0, 1'b0, 2'b10, 32'h0000_3000, 32'h0,        32'hCAFE_F00D, 5};
    vecs[7]  = '{1'b0, 1'b1, 2'b01, 32'h0000_3004, 32'hFFFF_BEEF, 32'h0,        2};
    vecs[8]  = '{1'b0, 1'b0, 2'b10, 32'h0000_3004, 32'h0,        32'h0000_BEEF, 5};
    vecs[9]  = '{1'b0, 1'b1, 2'b00, 32'h0000_3008, 32'h1234_5699, 32'h0,        1};
    vecs[10] = '{1'b0, 1'b0, 2'b11, 32'h0000_3008, 32'h0,        32'h0000_0099, 5};

    // Reset state
    #1 rst_in = 1'b0;
    #2;
    check("rst mem_a", mem_a, 32'h0);
    check("rst mem_wr", 32'(mem_wr), 32'h0);
    check("rst dones", {30'h0, if_done, ls_done}, 32'h0);
    check("rst if_data", if_data, 32'h0);
    check("rst ls_rdata", ls_rdata, 32'h0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);
    check("if_data hold", if_data, 32'h1234_5678);

    // Simultaneous fetch and load: load goes first
    ls_k = -1; if_k = -1; both = 0; ls_d = '0; if_d = '0;
    if_req = 1'b1; if_addr = 32'h1000;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'h2000;
    @(posedge clk_in);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_in);
      if (if_done && ls_done) both++;
      if (ls_done) begin ls_k = k; ls_d = ls_rdata; ls_req = 1'b0; end
      if (if_done) begin if_k = k; if_d = if_data; if_req = 1'b0; end
    end
    check("arb ls_done cycle", 32'(ls_k), 32'd5);
    check("arb ls_rdata", ls_d, 32'h1234_5678);
    check("arb if_done cycle", 32'(if_k), 32'd12);
    check("arb if_data", if_d, 32'h0000_0513);
    check("arb both done", 32'(both), 32'd0);

    // Store byte to I/O space held off by a full output buffer
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b00; ls_addr = 32'h0003_0000; ls_wdata = 32'h0000_0041;
    @(posedge clk_in);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      if (mem_wr !== 1'b0 || mem_a !== 32'h0) cnt++;
    end
    check("io stall bus active", 32'(cnt), 32'd0);
    io_buffer_full = 1'b0;
    writes = 0; dones = 0; w_a = '0; w_d = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      if (mem_wr) begin writes++; w_a = mem_a; w_d = mem_dout; end
      if (ls_done) begin dones++; ls_req = 1'b0; ls_wr = 1'b0; end
    end
    check("io writes", 32'(writes), 32'd1);
    check("io write addr", w_a, 32'h0003_0000);
    check("io write data", 32'(w_d), 32'h41);
    check("io ls_done count", 32'(dones), 32'd1);
    check("io ram byte", 32'(ram[32'h30000]), 32'h41);

    // Bus withdrawn right after first read byte is issued
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b01; ls_addr = 32'h0104;
    @(posedge clk_in);
    issues = 0; ls_k = -1; ls_d = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (mem_a == 32'h0104) issues++;
      if (ls_done) begin ls_k = k; ls_d = ls_rdata; ls_req = 1'b0; end
      rdy_in = (k >= 0 && k < 3) ? 1'b0 : 1'b1;
    end
    check("rdy reissue count", 32'(issues), 32'd2);
    check("rdy ls_done cycle", 32'(ls_k), 32'd7);
    check("rdy ls_rdata", ls_d, 32'h0000_ABCD);

    // Flush mid-fetch
    if_req = 1'b1; if_addr = 32'h1000;
    @(posedge clk_in);
    @(negedge clk_in);
    @(negedge clk_in);
    clear_in = 1'b1; if_req = 1'b0;
    @(negedge clk_in);
    clear_in = 1'b0;
    check("clear bus idle", mem_a, 32'h0);
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      if (if_done) dones++;
    end
    check("clear if_done count", 32'(dones), 32'd0);
    check("clear if_data hold", if_data, 32'h0000_0513);

    // Reset during a store
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b10; ls_addr = 32'h3010; ls_wdata = 32'h1122_3344;
    @(posedge clk_in);
    @(negedge clk_in);
    @(negedge clk_in);
    check("pre-rst store active", 32'(mem_wr), 32'h1);
    rst_in = 1'b0;
    #1;
    check("mid-rst mem_wr", 32'(mem_wr), 32'h0);
    check("mid-rst mem_a", mem_a, 32'h0);
    check("mid-rst mem_dout", 32'(mem_dout), 32'h0);
    check("mid-rst ls_rdata", ls_rdata, 32'h0);
    ls_req = 1'b0; ls_wr = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      if (ls_done) dones++;
    end
    check("post-rst ls_done count", 32'(dones), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
